jpeg_block_buffer: RTL

- Ping-pong 8x8 tile buffer placed directly upstream of the DCT input stage.
- Accepts 64 pixels per block (8-bit luma, row-major within the block) on a valid/ready stream and stores them.
- Once a block is complete, streams it out one sample per cycle, optionally level-shifted (pixel-128) and optionally transposed.
- Side-band markers give block framing and the row/column position of each sample.

---
 rtl/jpeg_block_buffer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jpeg_block_buffer.sv
// Ping-pong 8x8 tile buffer feeding the DCT input stage.
// Two 64-byte banks alternate between the write side, which fills a block
// in raster order, and the read side, which streams a completed block out.
// Read-out can be transposed and level-shifted.
module jpeg_block_buffer #(
  parameter int unsigned LEVEL_SHIFT = 1,
  parameter int unsigned TRANSPOSE   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sob,
  output logic       out_eob,
  output logic [2:0] out_row,
  output logic [2:0] out_col
);

  logic [7:0] mem_q [2][64];

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] full_q,    full_d;
  logic [5:0] wr_cnt_q,  wr_cnt_d;
  logic [5:0] rd_cnt_q,  rd_cnt_d;

  logic [7:0] out_data_q,  out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_sob_q,   out_sob_d;
  logic       out_eob_q,   out_eob_d;
  logic [2:0] out_row_q,   out_row_d;
  logic [2:0] out_col_q,   out_col_d;

  logic       wr_en;
  logic       load;
  logic [5:0] rd_idx;
  logic [7:0] rd_pix;

  // Write bank accepts data only while it does not hold a finished block.
  assign in_ready = !full_q[wr_bank_q];
  assign wr_en    = in_valid && in_ready;

  // Transposed read-out swaps the row and column fields of the counter.
  assign rd_idx = (TRANSPOSE != 0) ? {rd_cnt_q[2:0], rd_cnt_q[5:3]} : rd_cnt_q;
  assign rd_pix = mem_q[rd_bank_q][rd_idx];

  // Output register refills whenever it is empty or being drained this cycle.
  assign load = full_q[rd_bank_q] && (!out_valid_q || out_ready);

  // Next-state for bank bookkeeping and the output register.
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sob_d   = out_sob_q;
    out_eob_d   = out_eob_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    if (load) begin
      // Inverting the MSB equals subtracting 128 in two's complement.
      out_data_d  = (LEVEL_SHIFT != 0) ? {~rd_pix[7], rd_pix[6:0]} : rd_pix;
      out_valid_d = 1'b1;
      out_sob_d   = (rd_cnt_q == 6'd0);
      out_eob_d   = (rd_cnt_q == 6'd63);
      out_row_d   = rd_idx[5:3];
      out_col_d   = rd_idx[2:0];
      rd_cnt_d    = rd_cnt_q + 6'd1;
      // Write side never targets a full bank, so this clear and any set above
      // always hit different banks.
      if (rd_cnt_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_sob_d   = 1'b0;
      out_eob_d   = 1'b0;
    end
  end

  // Control and output state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      wr_cnt_q    <= 6'd0;
      rd_cnt_q    <= 6'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_row_q   <= 3'd0;
      out_col_q   <= 3'd0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sob_q   <= out_sob_d;
      out_eob_q   <= out_eob_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  // Pixel storage; contents survive reset since the counters make them stale.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_cnt_q] <= in_data;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sob   = out_sob_q;
  assign out_eob   = out_eob_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;

endmodule
